// File: rtl/multi_stage_bus_sync_pkg.sv
// Shared constants and helpers for the enable-qualified bus synchroniser.
package multi_stage_bus_sync_pkg;

  localparam int EN_MODE_LEVEL   = 0;
  localparam int EN_MODE_TOGGLE  = 1;
  localparam int SYNC_MIN_STAGES = 2;

  // Level mode fires on a rising edge only; toggle mode fires on any change.
  function automatic logic sync_edge(input int mode, input logic lvl, input logic prev);
    if (mode == EN_MODE_TOGGLE) begin
      return lvl ^ prev;
    end
    return lvl & ~prev;
  endfunction

endpackage

// File: rtl/multi_stage_bus_sync_sync_ff_chain.sv
// Generic N-stage reset-clearing synchroniser; Q follows D after NUM_STAGES CLK edges.
module sync_ff_chain #(
  parameter int WIDTH      = 1,
  parameter int NUM_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [NUM_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], D};
    end
  end

  assign Q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/multi_stage_bus_sync.sv
// Destination-side bus synchroniser: enable synchronised, edge-detected, then samples the stable bus.
// Data valid NUM_STAGES+1 CLK cycles after enable capture; no flow control.
module multi_stage_bus_sync
  import multi_stage_bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EN_MODE    = EN_MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 SYNC_EN_LVL
);

  if (NUM_STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("multi_stage_bus_sync: NUM_STAGES must be at least 2");
  end

  logic                 sync_lvl;
  logic                 prev_q;
  logic                 edge_det;
  logic                 pulse_q;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;

  sync_ff_chain #(
    .WIDTH      (1),
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (BUS_ENABLE),
    .Q   (sync_lvl)
  );

  assign edge_det = sync_edge(EN_MODE, sync_lvl, prev_q);

  // The bus itself is never synchronised: it is only sampled once the qualifier has settled.
  always_comb begin
    sync_bus_d = sync_bus_q;
    if (edge_det) begin
      sync_bus_d = UNSYNC_BUS;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q     <= 1'b0;
      pulse_q    <= 1'b0;
      sync_bus_q <= '0;
    end else begin
      prev_q     <= sync_lvl;
      pulse_q    <= edge_det;
      sync_bus_q <= sync_bus_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign SYNC_EN_LVL  = sync_lvl;

endmodule

// File: tb/tb_multi_stage_bus_sync.sv
// Bench for multi_stage_bus_sync: level instance (8b, 2 stages) and toggle instance (16b, 3 stages).
module tb_multi_stage_bus_sync;

  logic        CLK = 1'b0;
  logic        src_clk = 1'b0;
  logic        RST;

  logic [7:0]  lvl_dat;
  logic        lvl_en;
  logic [7:0]  lvl_sync;
  logic        lvl_pulse;
  logic        lvl_lvl;

  logic [15:0] tgl_dat;
  logic        tgl_en;
  logic [15:0] tgl_sync;
  logic        tgl_pulse;
  logic        tgl_lvl;

  int          n_vec = 0;
  int          n_err = 0;
  int          lvl_pulses = 0;
  int          tgl_pulses = 0;
  logic [7:0]  exp_lvl[$];
  logic [15:0] exp_tgl[$];

  always #50 CLK = ~CLK;
  always #135 src_clk = ~src_clk;

  multi_stage_bus_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .EN_MODE(0)) u_lvl (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (lvl_dat),
    .BUS_ENABLE   (lvl_en),
    .SYNC_BUS     (lvl_sync),
    .ENABLE_PULSE (lvl_pulse),
    .SYNC_EN_LVL  (lvl_lvl)
  );

  multi_stage_bus_sync #(.BUS_WIDTH(16), .NUM_STAGES(3), .EN_MODE(1)) u_tgl (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (tgl_dat),
    .BUS_ENABLE   (tgl_en),
    .SYNC_BUS     (tgl_sync),
    .ENABLE_PULSE (tgl_pulse),
    .SYNC_EN_LVL  (tgl_lvl)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every pulse must carry the oldest outstanding expected word.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (lvl_pulse) begin
        lvl_pulses++;
        if (exp_lvl.size() == 0) chk("lvl_spurious_pulse", 32'd1, 32'd0);
        else begin
          logic [7:0] e8;
          e8 = exp_lvl.pop_front();
          chk("lvl_data", {24'd0, lvl_sync}, {24'd0, e8});
        end
      end
      if (tgl_pulse) begin
        tgl_pulses++;
        if (exp_tgl.size() == 0) chk("tgl_spurious_pulse", 32'd1, 32'd0);
        else begin
          logic [15:0] e16;
          e16 = exp_tgl.pop_front();
          chk("tgl_data", {16'd0, tgl_sync}, {16'd0, e16});
        end
      end
    end
  end

  initial begin
    int cnt;
    int at;
    int base;
    int gap;

    RST     = 1'b0;
    lvl_en  = 1'b1;
    lvl_dat = 8'hA5;
    tgl_en  = 1'b0;
    tgl_dat = 16'h0;
    repeat (4) @(negedge CLK);
    chk("rst_lvl_sync", {24'd0, lvl_sync}, 32'h0);
    chk("rst_lvl_pulse", {31'd0, lvl_pulse}, 32'd0);
    chk("rst_lvl_level", {31'd0, lvl_lvl}, 32'd0);
    chk("rst_tgl_sync", {16'd0, tgl_sync}, 32'h0);
    chk("rst_tgl_pulse", {31'd0, tgl_pulse}, 32'd0);

    // Release with the enable already high: one pulse after edge 3.
    exp_lvl.push_back(8'hA5);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rel_level_after_e2", {31'd0, lvl_lvl}, 32'd1);
    chk("rel_no_pulse_e2", {31'd0, lvl_pulse}, 32'd0);
    @(negedge CLK);
    chk("rel_pulse_e3", {31'd0, lvl_pulse}, 32'd1);
    chk("rel_data_e3", {24'd0, lvl_sync}, 32'hA5);
    @(negedge CLK);
    chk("rel_pulse_off_e4", {31'd0, lvl_pulse}, 32'd0);

    lvl_en = 1'b0;
    repeat (5) @(negedge CLK);

    // Level mode: enable held 10 cycles, bus changed mid-hold must not be captured.
    lvl_dat = 8'h3C;
    lvl_en  = 1'b1;
    exp_lvl.push_back(8'h3C);
    cnt = 0;
    at  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (lvl_pulse) begin
        cnt++;
        at = i;
      end
      if (i == 5) lvl_dat = 8'hFF;
    end
    chk("lvl_pulse_count", cnt, 1);
    chk("lvl_pulse_cycle", at, 3);
    chk("lvl_recirc_hold", {24'd0, lvl_sync}, 32'h3C);
    lvl_en = 1'b0;
    repeat (5) @(negedge CLK);

    // Toggle mode: two transitions six cycles apart.
    tgl_dat = 16'h1234;
    tgl_en  = 1'b1;
    exp_tgl.push_back(16'h1234);
    cnt = 0;
    at  = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (tgl_pulse) begin
        cnt++;
        at = i;
      end
    end
    chk("tgl_rise_count", cnt, 1);
    chk("tgl_rise_cycle", at, 4);
    chk("tgl_rise_data", {16'd0, tgl_sync}, 32'h1234);
    tgl_dat = 16'hBEEF;
    tgl_en  = 1'b0;
    exp_tgl.push_back(16'hBEEF);
    cnt = 0;
    at  = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (tgl_pulse) begin
        cnt++;
        at = i;
      end
    end
    chk("tgl_fall_count", cnt, 1);
    chk("tgl_fall_cycle", at, 4);
    chk("tgl_fall_data", {16'd0, tgl_sync}, 32'hBEEF);

    // Reset one cycle into a transfer discards it and clears outputs at once.
    lvl_dat = 8'h77;
    lvl_en  = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_lvl_sync", {24'd0, lvl_sync}, 32'h0);
    chk("midrst_lvl_pulse", {31'd0, lvl_pulse}, 32'd0);
    chk("midrst_tgl_sync", {16'd0, tgl_sync}, 32'h0);
    lvl_en = 1'b0;
    repeat (3) @(negedge CLK);
    base = lvl_pulses;
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    chk("midrst_no_pulse", lvl_pulses - base, 0);
    chk("midrst_lvl_level", {31'd0, lvl_lvl}, 32'd0);

    // Random stress from an unrelated source clock at 0.37x, legal spacing.
    base = tgl_pulses;
    @(posedge src_clk);
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(5, 3);
      repeat (gap) @(posedge src_clk);
      tgl_dat = 16'($urandom);
      tgl_en  = ~tgl_en;
      exp_tgl.push_back(tgl_dat);
    end
    repeat (20) @(negedge CLK);
    chk("stress_pulse_count", tgl_pulses - base, 1000);
    chk("stress_queue_empty", exp_tgl.size(), 0);
    chk("lvl_queue_empty", exp_lvl.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
